conv_pack_acc_unpack: RTL and testbench

Consumer end of the packed dual-product DSP path. Each valid cycle it takes the raw 43-bit DSP product P = (a·2^16 + d)·b, unpacks it into the two signed 16-bit products a·b and d·b, and accumulates each over a convolution window delimited by pack_last. At window end it outputs both full-precision sums plus rounded, saturated int8 requantised values. It sits between the conv_mult_dsp array and the output feature-map writer.

---
 rtl/conv_pack_acc_unpack_if.sv | 17 +
 rtl/conv_pack_acc_unpack.sv | 88 ++++++++
 tb/tb_conv_pack_acc_unpack.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/conv_pack_acc_unpack_if.sv
// conv_pack_acc_unpack_if: packed-product input bus and window-result output bus
interface conv_pack_acc_unpack_if #(parameter int ACC_W = 24);
  logic              pack_vld;
  logic [42:0]       pack_p;
  logic              pack_last;
  logic              out_vld;
  logic [ACC_W-1:0]  out_sum_a;
  logic [ACC_W-1:0]  out_sum_d;
  logic [7:0]        out_q_a;
  logic [7:0]        out_q_d;
  logic              busy;
  logic              ovf_err;
  modport master (output pack_vld, pack_p, pack_last,
                  input out_vld, out_sum_a, out_sum_d, out_q_a, out_q_d, busy, ovf_err);
  modport slave (input pack_vld, pack_p, pack_last,
                 output out_vld, out_sum_a, out_sum_d, out_q_a, out_q_d, busy, ovf_err);
endinterface

// File: rtl/conv_pack_acc_unpack.sv
// conv_pack_acc_unpack: unpack dual 16-bit products from a packed DSP result,
// accumulate per window and emit full sums plus rounded, saturated int8 values.
module conv_pack_acc_unpack #(
  parameter int ACC_W    = 24,
  parameter int MAX_TAPS = 256,
  parameter int SHIFT    = 8
) (
  input logic                   sclk,
  input logic                   s_rst,
  conv_pack_acc_unpack_if.slave bus
);
  localparam int CW = $clog2(MAX_TAPS + 1);
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'((1 << SHIFT) >> 1);
  logic signed [15:0]      r_ab1, r_db1;
  logic                    r_vld1, r_last1;
  logic signed [ACC_W-1:0] r_acc_a, r_acc_d, w_sum_a, w_sum_d;
  logic signed [ACC_W-1:0] r_fin_a, r_fin_d;
  logic                    r_fin_vld;
  logic [CW-1:0]           r_cnt;
  logic                    r_busy, r_ovf, r_vld;
  logic [ACC_W-1:0]        r_sum_a, r_sum_d;
  logic [7:0]              r_q_a, r_q_d;
  function automatic logic [7:0] requant(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W:0] r;
    r = $signed({s[ACC_W-1], s}) + RND;
    r = r >>> SHIFT;
    return r > 127 ? 8'h7f : r < -128 ? 8'h80 : r[7:0];
  endfunction
  always_comb begin
    w_sum_a = r_acc_a + {{(ACC_W-16){r_ab1[15]}}, r_ab1};
    w_sum_d = r_acc_d + {{(ACC_W-16){r_db1[15]}}, r_db1};
  end
  // Low half is d*b; the upper half borrowed one whenever d*b went negative.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_ab1     <= '0;
      r_db1     <= '0;
      r_vld1    <= 1'b0;
      r_last1   <= 1'b0;
      r_acc_a   <= '0;
      r_acc_d   <= '0;
      r_fin_a   <= '0;
      r_fin_d   <= '0;
      r_fin_vld <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
      r_vld     <= 1'b0;
      r_sum_a   <= '0;
      r_sum_d   <= '0;
      r_q_a     <= '0;
      r_q_d     <= '0;
    end else begin
      r_vld1 <= bus.pack_vld;
      if (bus.pack_vld) begin
        r_db1   <= bus.pack_p[15:0];
        r_ab1   <= bus.pack_p[31:16] + {15'b0, bus.pack_p[15]};
        r_last1 <= bus.pack_last;
      end
      r_fin_vld <= r_vld1 & r_last1;
      r_busy    <= r_vld1 | (r_busy & ~r_fin_vld);
      if (r_vld1) begin
        r_acc_a <= r_last1 ? '0 : w_sum_a;
        r_acc_d <= r_last1 ? '0 : w_sum_d;
        r_cnt   <= r_last1 ? '0 : r_cnt == CW'(MAX_TAPS) ? r_cnt : r_cnt + 1'b1;
        if (!r_last1 && r_cnt >= CW'(MAX_TAPS - 1)) r_ovf <= 1'b1;
        if (r_last1) begin
          r_fin_a <= w_sum_a;
          r_fin_d <= w_sum_d;
        end
      end
      r_vld <= r_fin_vld;
      if (r_fin_vld) begin
        r_sum_a <= r_fin_a;
        r_sum_d <= r_fin_d;
        r_q_a   <= requant(r_fin_a);
        r_q_d   <= requant(r_fin_d);
      end
    end
  end
  assign bus.out_vld   = r_vld;
  assign bus.out_sum_a = r_sum_a;
  assign bus.out_sum_d = r_sum_d;
  assign bus.out_q_a   = r_q_a;
  assign bus.out_q_d   = r_q_d;
  assign bus.busy      = r_busy;
  assign bus.ovf_err   = r_ovf;
endmodule

// File: tb/tb_conv_pack_acc_unpack.sv
// tb_conv_pack_acc_unpack: random and directed windows against an arithmetic
// model of the dual-product accumulator.
module tb_conv_pack_acc_unpack;
  localparam int MAXT = 4;
  logic sclk = 1'b0;
  logic s_rst;
  always #5 sclk = ~sclk;
  conv_pack_acc_unpack_if #(.ACC_W(24)) bus();
  conv_pack_acc_unpack #(.ACC_W(24), .MAX_TAPS(MAXT), .SHIFT(8)) dut (
    .sclk(sclk),
    .s_rst(s_rst),
    .bus(bus)
  );
  typedef struct {longint sa; longint sd; longint qa; longint qd; longint ovf;} res_t;
  res_t exp_q[$];
  int checks = 0;
  int failures = 0;
  longint m_sa, m_sd;
  int m_len;
  bit m_ovf;
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic longint wrap24(input longint s);
    logic signed [23:0] t;
    t = s[23:0];
    return longint'(t);
  endfunction
  function automatic longint rq(input longint s);
    longint r, q;
    r = s + 128;
    q = r >= 0 ? r / 256 : -((-r + 255) / 256);
    return q > 127 ? 127 : q < -128 ? -128 : q;
  endfunction
  task automatic tap(input int a, input int d, input int b, input bit last);
    longint p;
    res_t e;
    p = (longint'(a) * 65536 + d) * b;
    bus.pack_vld = 1'b1;
    bus.pack_p = p[42:0];
    bus.pack_last = last;
    m_sa += a * b;
    m_sd += d * b;
    m_len++;
    if (last) begin
      if (m_len > MAXT) m_ovf = 1'b1;
      e.sa = wrap24(m_sa);
      e.sd = wrap24(m_sd);
      e.qa = rq(e.sa);
      e.qd = rq(e.sd);
      e.ovf = m_ovf;
      exp_q.push_back(e);
      m_sa = 0;
      m_sd = 0;
      m_len = 0;
    end
    @(negedge sclk);
    bus.pack_vld = 1'b0;
    bus.pack_last = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge sclk);
  endtask
  task automatic do_reset();
    s_rst = 1'b1;
    bus.pack_vld = 1'b0;
    bus.pack_last = 1'b0;
    idle(2);
    s_rst = 1'b0;
    exp_q.delete();
    m_sa = 0;
    m_sd = 0;
    m_len = 0;
    m_ovf = 1'b0;
  endtask
  function automatic int r8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction
  always @(negedge sclk) begin
    res_t e;
    if (!s_rst && bus.out_vld) begin
      if (exp_q.size() == 0) chk("unexpected_out_vld", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sum_a", longint'($signed(bus.out_sum_a)), e.sa);
        chk("sum_d", longint'($signed(bus.out_sum_d)), e.sd);
        chk("q_a", longint'($signed(bus.out_q_a)), e.qa);
        chk("q_d", longint'($signed(bus.out_q_d)), e.qd);
        chk("ovf_at_out", longint'(bus.ovf_err), e.ovf);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    bus.pack_p = '0;
    @(negedge sclk);
    do_reset();
    chk("rst_out_vld", longint'(bus.out_vld), 0);
    chk("rst_sum_a", longint'(bus.out_sum_a), 0);
    chk("rst_sum_d", longint'(bus.out_sum_d), 0);
    chk("rst_q_a", longint'(bus.out_q_a), 0);
    chk("rst_q_d", longint'(bus.out_q_d), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_ovf", longint'(bus.ovf_err), 0);
    tap(3, -2, 5, 1'b1);
    idle(1);
    chk("latency_early", longint'(bus.out_vld), 0);
    idle(1);
    chk("latency_on", longint'(bus.out_vld), 1);
    idle(1);
    chk("pulse_one_cycle", longint'(bus.out_vld), 0);
    chk("hold_sum_a", longint'($signed(bus.out_sum_a)), 15);
    chk("idle_busy", longint'(bus.busy), 0);
    for (int i = 0; i < 9; i++) begin
      tap(127, -128, 127, i == 8);
      if (i == 2) chk("busy_mid", longint'(bus.busy), 1);
    end
    idle(4);
    chk("busy_after", longint'(bus.busy), 0);
    chk("ovf_long", longint'(bus.ovf_err), 1);
    do_reset();
    chk("ovf_cleared", longint'(bus.ovf_err), 0);
    tap(3, -3, 128, 1'b1);
    tap(383, 0, 1, 1'b1);
    tap(1, 2, 3, 1'b0);
    tap(-1, 2, 4, 1'b1);
    idle(4);
    for (int i = 0; i < 4; i++) tap(r8(), r8(), r8(), 1'b0);
    idle(3);
    do_reset();
    tap(7, -9, 11, 1'b1);
    idle(4);
    for (int w = 0; w < 30; w++) begin
      int len;
      len = int'($urandom_range(1, MAXT));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) idle(1);
        tap(r8(), r8(), r8(), i == len - 1);
      end
    end
    idle(4);
    chk("ovf_exact_max", longint'(bus.ovf_err), 0);
    for (int i = 0; i < 5; i++) tap(r8(), r8(), r8(), i == 4);
    idle(4);
    chk("ovf_set", longint'(bus.ovf_err), 1);
    tap(r8(), r8(), r8(), 1'b1);
    idle(4);
    chk("ovf_sticky", longint'(bus.ovf_err), 1);
    do_reset();
    chk("ovf_reset", longint'(bus.ovf_err), 0);
    idle(5);
    chk("pending", longint'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
